// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the instruction encoder and the main control decoder.
package mips_isa_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned KIND_W  = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [KIND_W-1:0] KIND_R   = 2'd0;
    localparam logic [KIND_W-1:0] KIND_LW  = 2'd1;
    localparam logic [KIND_W-1:0] KIND_SW  = 2'd2;
    localparam logic [KIND_W-1:0] KIND_BEQ = 2'd3;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [15:0]       imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_field_packer.sv
// Packs decoded instruction fields into a 32-bit MIPS machine word (combinational).
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  instr_fields_t        fields,
    output logic [INSTR_W-1:0]   word_c
);

    always_comb begin
        word_c = '0;
        case (fields.kind)
            KIND_R:   word_c = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
            KIND_LW:  word_c = {OP_LW,    fields.rs, fields.rt, fields.imm};
            KIND_SW:  word_c = {OP_SW,    fields.rs, fields.rt, fields.imm};
            KIND_BEQ: word_c = {OP_BEQ,   fields.rs, fields.rt, fields.imm};
            default:  word_c = '0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes field tuples into MIPS words and writes them sequentially into instruction memory.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imemWe,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [31:0]       imemData,
    output logic [ADDR_W:0]   wordCount,
    output logic              busy,
    output logic              full,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state, state_n;
    logic [CNT_W-1:0]   acc_cnt, acc_n;
    logic               fin_pend, fin_n;
    logic               ready_n, we_n, full_n, busy_n, done_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [31:0]        data_n;
    logic [CNT_W-1:0]   wc_n;
    logic               accept;
    logic [31:0]        packed_word_c;
    instr_fields_t      fields;

    assign fields = {in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm};
    assign accept = in_valid && in_ready;

    instr_field_packer u_packer (
        .fields (fields),
        .word_c (packed_word_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_n = state;
        acc_n   = acc_cnt;
        fin_n   = fin_pend;
        we_n    = 1'b0;
        addr_n  = imemAddr;
        data_n  = imemData;
        wc_n    = wordCount + CNT_W'(imemWe);
        full_n  = full;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_LOAD;
                    acc_n   = '0;
                    wc_n    = '0;
                    fin_n   = 1'b0;
                    full_n  = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    acc_n  = acc_cnt + CNT_W'(1);
                    we_n   = 1'b1;
                    addr_n = BASE + acc_cnt[ADDR_W-1:0];
                    data_n = packed_word_c;
                end
                // A finish that arrived with an accept closes the program after that write lands
                if (fin_pend) begin
                    state_n = S_DONE;
                    fin_n   = 1'b0;
                end else if (accept && ((acc_cnt + CNT_W'(1)) == DEPTH_CNT)) begin
                    full_n = 1'b1;
                    if (finish) fin_n = 1'b1;
                    else        state_n = S_FULL;
                end else if (finish) begin
                    if (accept) fin_n = 1'b1;
                    else        state_n = S_DONE;
                end
            end
            S_FULL: begin
                if (finish) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n == S_LOAD) && !fin_n && (acc_n < DEPTH_CNT);
        busy_n  = (state_n == S_LOAD) || (state_n == S_FULL);
        done_n  = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc_cnt   <= '0;
            fin_pend  <= 1'b0;
            in_ready  <= 1'b0;
            imemWe    <= 1'b0;
            imemAddr  <= BASE;
            imemData  <= '0;
            wordCount <= '0;
            busy      <= 1'b0;
            full      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            acc_cnt   <= acc_n;
            fin_pend  <= fin_n;
            in_ready  <= ready_n;
            imemWe    <= we_n;
            imemAddr  <= addr_n;
            imemData  <= data_n;
            wordCount <= wc_n;
            busy      <= busy_n;
            full      <= full_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: vector table, corner sequences and a randomized program model.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, finish, in_valid;
    logic [1:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic        sel;

    logic        a_ready, a_we, a_busy, a_full, a_done;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic [8:0]  a_wc;
    logic        b_ready, b_we, b_busy, b_full, b_done;
    logic [7:0]  b_addr;
    logic [31:0] b_data;
    logic [8:0]  b_wc;
    logic        start_a, start_b;

    logic        o_ready, o_we, o_busy, o_full, o_done;
    logic [7:0]  o_addr;
    logic [31:0] o_data;
    logic [8:0]  o_wc;

    int total = 0;
    int bad   = 0;

    localparam int P_IDLE = 0;
    localparam int P_OPEN = 1;
    localparam int P_DONE = 2;
    int m_phase;
    int m_acc;
    bit m_fin;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign o_ready = sel ? b_ready : a_ready;
    assign o_we    = sel ? b_we    : a_we;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_full  = sel ? b_full  : a_full;
    assign o_done  = sel ? b_done  : a_done;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_data  = sel ? b_data  : a_data;
    assign o_wc    = sel ? b_wc    : a_wc;

    instr_encode_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .finish(finish),
        .in_valid(in_valid), .in_ready(a_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .imemWe(a_we), .imemAddr(a_addr),
        .imemData(a_data), .wordCount(a_wc), .busy(a_busy), .full(a_full), .done(a_done)
    );

    instr_encode_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .finish(finish),
        .in_valid(in_valid), .in_ready(b_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .imemWe(b_we), .imemAddr(b_addr),
        .imemData(b_data), .wordCount(b_wc), .busy(b_busy), .full(b_full), .done(b_done)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[5];

    function automatic int depth_of();
        return sel ? 4 : 256;
    endfunction

    function automatic int base_of();
        return sel ? 8 : 0;
    endfunction

    function automatic logic [31:0] enc(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                        input logic [15:0] imm);
        logic [31:0] hi;
        hi = 32'(rs) << 21 | 32'(rt) << 16;
        if (k == 2'd0) return hi | 32'(rd) << 11 | 32'(sh) << 6 | 32'(fn);
        if (k == 2'd1) return 32'h8C00_0000 | hi | 32'(imm);
        if (k == 2'd2) return 32'hAC00_0000 | hi | 32'(imm);
        return 32'h1000_0000 | hi | 32'(imm);
    endfunction

    function automatic logic m_ready();
        return (m_phase == P_OPEN) && !m_fin && (m_acc < depth_of());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_acc   = 0;
        m_fin   = 1'b0;
    endtask

    task automatic rand_fields();
        in_kind  = 2'($urandom_range(3, 0));
        in_rs    = 5'($urandom);
        in_rt    = 5'($urandom);
        in_rd    = 5'($urandom);
        in_shamt = 5'($urandom);
        in_funct = 6'($urandom);
        in_imm   = 16'($urandom);
    endtask

    // One clock edge: predict from the model, advance, then compare every output.
    task automatic step();
        logic        acc_now, fin_now, start_now;
        int          acc_old, exp_a;
        logic [31:0] exp_w;
        acc_now   = in_valid && m_ready();
        fin_now   = (m_phase == P_OPEN) && finish;
        start_now = (m_phase != P_OPEN) && start;
        exp_w     = enc(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm);
        exp_a     = base_of() + m_acc;
        acc_old   = m_acc;
        @(posedge clk);
        #1;
        if (start_now) begin
            m_phase = P_OPEN;
            m_acc   = 0;
            m_fin   = 1'b0;
        end else if (m_phase == P_OPEN) begin
            if (acc_now) m_acc++;
            if (fin_now) m_fin = 1'b1;
            if (m_fin && !acc_now) m_phase = P_DONE;
        end
        chk("imemWe", 32'(o_we), 32'(acc_now));
        if (acc_now) begin
            chk("imemAddr", 32'(o_addr), 32'(exp_a));
            chk("imemData", o_data, exp_w);
        end
        chk("wordCount", 32'(o_wc), start_now ? 32'd0 : 32'(acc_old));
        chk("in_ready", 32'(o_ready), 32'(m_ready()));
        chk("busy", 32'(o_busy), 32'(m_phase == P_OPEN));
        chk("done", 32'(o_done), 32'(m_phase == P_DONE));
        chk("full", 32'(o_full), 32'(m_acc == depth_of()));
    endtask

    task automatic close_program();
        in_valid = 1'b0;
        start    = 1'b0;
        for (int k = 0; k < 4 && m_phase == P_OPEN; k++) begin
            finish = 1'b1;
            step();
        end
        finish = 1'b0;
        chk("close reaches done", 32'(m_phase), 32'(P_DONE));
    endtask

    task automatic random_programs(input int n_prog, input int n_cyc);
        for (int p = 0; p < n_prog; p++) begin
            start = 1'b1; in_valid = 1'b0; finish = 1'b0;
            step();
            for (int c = 0; c < n_cyc; c++) begin
                rand_fields();
                in_valid = ($urandom_range(3, 0) != 0);
                finish   = ($urandom_range(24, 0) == 0);
                start    = ($urandom_range(9, 0) == 0);
                step();
            end
            close_program();
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 32'h0022_1820};
        vecs[1] = '{2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 32'h8D28_0004};
        vecs[2] = '{2'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0008, 32'hAD28_0008};
        vecs[3] = '{2'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 32'h1022_FFFF};
        vecs[4] = '{2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 32'h0022_1820};

        sel = 1'b0; rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        rand_fields();
        model_reset();

        // Reset values
        #12;
        chk("rst imemWe", 32'(a_we), 32'd0);
        chk("rst imemAddr", 32'(a_addr), 32'd0);
        chk("rst imemAddr base8", 32'(b_addr), 32'd8);
        chk("rst imemData", a_data, 32'd0);
        chk("rst wordCount", 32'(a_wc), 32'd0);
        chk("rst in_ready", 32'(a_ready), 32'd0);
        chk("rst busy/full/done", {29'd0, a_busy, a_full, a_done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start together with finish in IDLE: start wins
        start = 1'b1; finish = 1'b1;
        step();
        start = 1'b0; finish = 1'b0;

        // Vector table: back-to-back accepts, finish coinciding with the last
        for (int i = 0; i < 5; i++) begin
            in_kind = vecs[i].kind; in_rs = vecs[i].rs; in_rt = vecs[i].rt; in_rd = vecs[i].rd;
            in_shamt = vecs[i].shamt; in_funct = vecs[i].funct; in_imm = vecs[i].imm;
            in_valid = 1'b1;
            finish   = (i == 4);
            step();
            chk("table word", o_data, vecs[i].word);
            chk("table addr", 32'(o_addr), 32'(i));
        end
        in_valid = 1'b0; finish = 1'b0;
        step();
        chk("done after finish", 32'(o_done), 32'd1);
        chk("busy after finish", 32'(o_busy), 32'd0);
        chk("final wordCount", 32'(o_wc), 32'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;

        // Start in DONE restarts at BASE_ADDR; a start during LOAD is ignored
        start = 1'b1;
        step();
        chk("restart done", 32'(o_done), 32'd0);
        chk("restart wordCount", 32'(o_wc), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            in_valid = 1'b1;
            start    = (i == 2);
            step();
            if (i == 0) chk("restart first addr", 32'(o_addr), 32'd0);
        end
        start = 1'b0; in_valid = 1'b0;
        step();
        chk("no clear on start in LOAD", 32'(o_wc), 32'd4);

        // Reset while a write is pending
        rand_fields();
        in_valid = 1'b1;
        step();
        chk("write pending before reset", 32'(o_we), 32'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst imemWe", 32'(o_we), 32'd0);
        chk("mid rst imemAddr", 32'(o_addr), 32'd0);
        chk("mid rst imemData", o_data, 32'd0);
        chk("mid rst wordCount", 32'(o_wc), 32'd0);
        chk("mid rst flags", {28'd0, o_ready, o_busy, o_full, o_done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("imemWe held in reset", 32'(o_we), 32'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        step();
        chk("post-reset first addr", 32'(o_addr), 32'd0);
        in_valid = 1'b0;
        close_program();

        random_programs(4, 60);

        // DEPTH=4, BASE_ADDR=8 instance: fifth tuple is held off
        sel = 1'b1;
        model_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rand_fields();
            in_valid = 1'b1;
            step();
            if (i == 3) begin
                chk("depth4 full", 32'(o_full), 32'd1);
                chk("depth4 ready low", 32'(o_ready), 32'd0);
                chk("depth4 last addr", 32'(o_addr), 32'd11);
            end
        end
        chk("depth4 no fifth write", 32'(o_we), 32'd0);
        chk("depth4 wordCount", 32'(o_wc), 32'd4);
        finish = 1'b1;
        step();
        finish = 1'b0; in_valid = 1'b0;
        chk("depth4 done", 32'(o_done), 32'd1);
        chk("depth4 final wordCount", 32'(o_wc), 32'd4);

        random_programs(4, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
